// File: rtl/datapath_tipor_pipe.sv
// rtl/datapath_tipor_pipe.sv - two-stage R-type datapath: register bank, ALU, writeback, valid/ready flow control
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready instruction handshake (instruccion_tr)
//   out_valid/out_ready result handshake
//   tr_salida_final   ALU or LDI result
//   tr_zf             result is zero
//   tr_dest           destination register of the result
//   tr_err            result belongs to an illegal opcode/funct
//
// Optional feature macro: DATAPATH_TIPOR_EXT_OPS_EN adds AND, OR, NOR and SLL functs.

module datapath_tipor_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruccion_tr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] tr_salida_final,
    output logic              tr_zf,
    output logic [REG_AW-1:0] tr_dest,
    output logic              tr_err
);

    localparam logic [5:0] OP_EXEC = 6'b000000;
    localparam logic [5:0] OP_PEEK = 6'b000001;
    localparam logic [5:0] OP_LDI  = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
`ifdef DATAPATH_TIPOR_EXT_OPS_EN
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLL  = 6'b000000;
`endif

    // S1: registered instruction
    logic        s1_valid;
    logic [31:0] s1_instr;

    // S2 write-enable; the other S2 fields are the output ports themselves
    logic        s2_we;

    // r0 is not stored: it always reads as zero
    logic [DATA_W-1:0] regs [1:NREG-1];

    logic stall;
    logic s2_leave;
    logic wb_en;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign s2_leave = out_valid & out_ready;
    // Writes to r0 are dropped here, which also keeps r0 out of the bypass
    assign wb_en    = s2_leave & s2_we & (tr_dest != '0);

    logic [5:0]        op;
    logic [5:0]        fn;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rt_a;
    logic [REG_AW-1:0] rd_a;

    assign op   = s1_instr[31:26];
    assign fn   = s1_instr[5:0];
    assign rs_a = REG_AW'(s1_instr[25:21]);
    assign rt_a = REG_AW'(s1_instr[20:16]);
    assign rd_a = REG_AW'(s1_instr[15:11]);

    // Operand read with bypass from the result retiring on this same edge
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_a == REG_AW'(i)) rs_val = regs[i];
            if (rt_a == REG_AW'(i)) rt_val = regs[i];
        end
        if (wb_en && (tr_dest == rs_a)) rs_val = tr_salida_final;
        if (wb_en && (tr_dest == rt_a)) rt_val = tr_salida_final;
    end

    logic [DATA_W-1:0] alu_res;
    logic              alu_bad;

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        case (fn)
            FN_ADD: alu_res = rs_val + rt_val;
            FN_SUB: alu_res = rs_val - rt_val;
            FN_SLT: alu_res[0] = ($signed(rs_val) < $signed(rt_val));
`ifdef DATAPATH_TIPOR_EXT_OPS_EN
            FN_AND: alu_res = rs_val & rt_val;
            FN_OR:  alu_res = rs_val | rt_val;
            FN_NOR: alu_res = ~(rs_val | rt_val);
            FN_SLL: alu_res = rt_val << s1_instr[10:6];
`endif
            default: alu_bad = 1'b1;
        endcase
    end

    logic [DATA_W-1:0] ex_res;
    logic              ex_err;
    logic              ex_we;
    logic [REG_AW-1:0] ex_dest;

    always_comb begin
        ex_res  = '0;
        ex_err  = 1'b0;
        ex_we   = 1'b0;
        ex_dest = rd_a;
        case (op)
            OP_EXEC, OP_PEEK: begin
                if (alu_bad) begin
                    ex_err = 1'b1;
                end else begin
                    ex_res = alu_res;
                    ex_we  = (op == OP_EXEC);
                end
            end
            OP_LDI: begin
                ex_res  = DATA_W'(s1_instr[15:0]);
                ex_dest = rt_a;
                ex_we   = 1'b1;
            end
            default: ex_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over a retiring result, so its writeback is lost
            s1_valid        <= 1'b0;
            s1_instr        <= '0;
            out_valid       <= 1'b0;
            tr_salida_final <= '0;
            tr_zf           <= 1'b0;
            tr_dest         <= '0;
            tr_err          <= 1'b0;
            s2_we           <= 1'b0;
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wb_en && (tr_dest == REG_AW'(i))) regs[i] <= tr_salida_final;
            end
            if (!stall) begin
                s1_valid  <= in_valid;
                if (in_valid) s1_instr <= instruccion_tr;
                // Bubbles move down as-is; stale S2 data is masked by out_valid
                out_valid <= s1_valid;
                if (s1_valid) begin
                    tr_salida_final <= ex_res;
                    tr_zf           <= (ex_res == '0);
                    tr_dest         <= ex_dest;
                    tr_err          <= ex_err;
                    s2_we           <= ex_we;
                end
            end
        end
    end

endmodule

// File: tb/tb_datapath_tipor_pipe.sv
// tb/tb_datapath_tipor_pipe.sv - self-checking bench for datapath_tipor_pipe

module tb_datapath_tipor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruccion_tr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] tr_salida_final;
    logic        tr_zf;
    logic [4:0]  tr_dest;
    logic        tr_err;

    always #5 clk = ~clk;

    datapath_tipor_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruccion_tr  (instruccion_tr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .tr_salida_final (tr_salida_final),
        .tr_zf           (tr_zf),
        .tr_dest         (tr_dest),
        .tr_err          (tr_err)
    );

    localparam logic [5:0] EXEC = 6'b000000;
    localparam logic [5:0] PEEK = 6'b000001;
    localparam logic [5:0] BAD  = 6'b000111;
    localparam logic [5:0] ADD  = 6'b100000;
    localparam logic [5:0] SUB  = 6'b100010;
    localparam logic [5:0] SLT  = 6'b101010;
    localparam logic [5:0] FAND = 6'b100100;
    localparam logic [5:0] FOR  = 6'b100101;
    localparam logic [5:0] FNOR = 6'b100111;
    localparam logic [5:0] FSLL = 6'b000000;
    localparam logic [5:0] FBAD = 6'b111111;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic        zf;
        logic [4:0]  dest;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    vec_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   out_idx = 0;

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ldi(input logic [4:0] rt, input logic [15:0] imm);
        return {6'b000010, 5'd0, rt, imm};
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] res,
                                input logic [4:0] dest, input logic err);
        vec_t v;
        v.instr = instr;
        v.res   = res;
        v.zf    = (res == 32'd0);
        v.dest  = dest;
        v.err   = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshaken result is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result %0h dest %0d, expected none",
                         tr_salida_final, tr_dest);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("out%0d_res", out_idx),  tr_salida_final, mon_e.res);
                check($sformatf("out%0d_zf", out_idx),   32'(tr_zf),      32'(mon_e.zf));
                check($sformatf("out%0d_dest", out_idx), 32'(tr_dest),    32'(mon_e.dest));
                check($sformatf("out%0d_err", out_idx),  32'(tr_err),     32'(mon_e.err));
            end
            out_idx++;
        end
    end

    task automatic issue(input vec_t v);
        bit done = 1'b0;
        @(posedge clk);
        #1;
        in_valid       = 1'b1;
        instruccion_tr = v.instr;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v);
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready 0 for 20 cycles, expected acceptance");
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        instruccion_tr = '0;
        out_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_result",    tr_salida_final, 32'd0);
        check("rst_zf",        32'(tr_zf),      32'd0);
        check("rst_dest",      32'(tr_dest),    32'd0);
        check("rst_err",       32'(tr_err),     32'd0);

        tbl.push_back(mk(ldi(9, 16'd9),                  32'd9,  5'd9,  1'b0));
        tbl.push_back(mk(ldi(17, 16'd17),                32'd17, 5'd17, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 9, 17, 7, 0, ADD),  32'd26, 5'd7,  1'b0));
        tbl.push_back(mk(rtype(PEEK, 7, 9, 7, 0, ADD),   32'd35, 5'd7,  1'b0));
        tbl.push_back(mk(ldi(2, 16'd2),                  32'd2,  5'd2,  1'b0));
        tbl.push_back(mk(rtype(EXEC, 7, 2, 3, 0, SUB),   32'd24, 5'd3,  1'b0));
        tbl.push_back(mk(rtype(EXEC, 2, 7, 4, 0, SLT),   32'd1,  5'd4,  1'b0));
        tbl.push_back(mk(rtype(EXEC, 7, 2, 4, 0, SLT),   32'd0,  5'd4,  1'b0));
        tbl.push_back(mk(ldi(5, 16'hFFFF),               32'h0000FFFF, 5'd5, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 0, 2, 6, 0, SUB),   32'hFFFFFFFE, 5'd6, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 6, 2, 8, 0, SLT),   32'd1,  5'd8,  1'b0));
        tbl.push_back(mk(rtype(BAD, 9, 17, 11, 0, ADD),  32'd0,  5'd11, 1'b1));
        tbl.push_back(mk(rtype(EXEC, 9, 17, 12, 0, FBAD), 32'd0, 5'd12, 1'b1));
        tbl.push_back(mk(rtype(PEEK, 11, 12, 13, 0, ADD), 32'd0, 5'd13, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 9, 17, 0, 0, ADD),  32'd26, 5'd0,  1'b0));
        tbl.push_back(mk(rtype(PEEK, 0, 0, 1, 0, ADD),   32'd0,  5'd1,  1'b0));
        tbl.push_back(mk(rtype(PEEK, 7, 0, 1, 0, ADD),   32'd26, 5'd1,  1'b0));
        tbl.push_back(mk(ldi(20, 16'h00F0),              32'hF0, 5'd20, 1'b0));
        tbl.push_back(mk(ldi(21, 16'h003C),              32'h3C, 5'd21, 1'b0));
        tbl.push_back(mk(ldi(25, 16'd1),                 32'd1,  5'd25, 1'b0));
`ifdef DATAPATH_TIPOR_EXT_OPS_EN
        tbl.push_back(mk(rtype(EXEC, 20, 21, 22, 0, FAND), 32'h30, 5'd22, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 20, 21, 23, 0, FOR),  32'hFC, 5'd23, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 0, 0, 23, 0, FNOR),   32'hFFFFFFFF, 5'd23, 1'b0));
        tbl.push_back(mk(rtype(EXEC, 0, 25, 24, 4, FSLL),  32'd16, 5'd24, 1'b0));
        tbl.push_back(mk(rtype(PEEK, 22, 0, 1, 0, ADD),    32'h30, 5'd1,  1'b0));
`else
        tbl.push_back(mk(rtype(EXEC, 20, 21, 22, 0, FAND), 32'd0, 5'd22, 1'b1));
        tbl.push_back(mk(rtype(EXEC, 20, 21, 23, 0, FOR),  32'd0, 5'd23, 1'b1));
        tbl.push_back(mk(rtype(EXEC, 0, 0, 23, 0, FNOR),   32'd0, 5'd23, 1'b1));
        tbl.push_back(mk(rtype(EXEC, 0, 25, 24, 4, FSLL),  32'd0, 5'd24, 1'b1));
        tbl.push_back(mk(rtype(PEEK, 22, 0, 1, 0, ADD),    32'd0, 5'd1,  1'b0));
`endif

        for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);
        idle();
        drain("table_drain");

        // Backpressure: two in flight, third waiting at the input
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(mk(ldi(26, 16'h1234), 32'h1234, 5'd26, 1'b0));
        issue(mk(rtype(EXEC, 26, 26, 27, 0, ADD), 32'h2468, 5'd27, 1'b0));
        @(posedge clk);
        #1;
        instruccion_tr = rtype(PEEK, 27, 26, 1, 0, ADD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_result", c),    tr_salida_final, 32'h1234);
            check($sformatf("stall%0d_dest", c),      32'(tr_dest),   32'd26);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(mk(rtype(PEEK, 27, 26, 1, 0, ADD), 32'h369C, 5'd1, 1'b0));
        idle();
        drain("stall_drain");

        // Reset while stalled with a retiring result
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(mk(ldi(28, 16'd5), 32'd5, 5'd28, 1'b0));
        issue(mk(ldi(29, 16'd6), 32'd6, 5'd29, 1'b0));
        idle();
        @(negedge clk);
        check("stall2_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid),  32'd0);
        check("rst2_in_ready",  32'(in_ready),   32'd1);
        check("rst2_result",    tr_salida_final, 32'd0);
        check("rst2_dest",      32'(tr_dest),    32'd0);
        check("rst2_err",       32'(tr_err),     32'd0);
        issue(mk(rtype(PEEK, 28, 29, 1, 0, ADD), 32'd0, 5'd1, 1'b0));
        issue(mk(rtype(PEEK, 9, 17, 2, 0, ADD),  32'd0, 5'd2, 1'b0));
        issue(mk(rtype(PEEK, 7, 26, 3, 0, ADD),  32'd0, 5'd3, 1'b0));
        idle();
        drain("rst2_drain");
        check("output_count", 32'(out_idx), 32'(tbl.size() + 6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
